// File: rtl/keypad_scan.sv
// 4x4 matrix keypad scanner: strobes one active-low column per slot, samples rows,
// classifies each 4-slot frame and debounces presses/releases into single-cycle events.
`timescale 1ns/1ps
module keypad_scan #(
  parameter int SCAN_DIV = 1000,
  parameter int DEBOUNCE = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_down
);

  localparam int SLOT_W = $clog2(SCAN_DIV);
  localparam int CNT_W  = (DEBOUNCE < 2) ? 1 : $clog2(DEBOUNCE + 1);
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SCAN_DIV - 1);
  localparam logic [SLOT_W-1:0] SLOT_ONE  = SLOT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_DONE  = CNT_W'(DEBOUNCE);

  typedef enum logic [1:0] {ST_IDLE, ST_PRESS, ST_HELD, ST_RELEASE} state_e;
  typedef enum logic [1:0] {FR_NONE, FR_SINGLE, FR_MULTI} frame_e;

  logic [3:0]        row_meta_q, row_sync_q;
  logic [SLOT_W-1:0] slot_q;
  logic [1:0]        col_idx_q;
  logic [15:0]       map_q, map_d, sample_map;
  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [3:0]        cand_q, cand_d;
  logic [3:0]        key_code_q, key_code_d;
  logic              key_valid_q, key_valid_d;
  logic              key_down_q, key_down_d;

  logic              slot_last, frame_end;
  frame_e            frame_kind;
  logic [3:0]        frame_key;
  logic              accept, drop;

  // NOTE: non-blocking so the second stage takes the first stage's previous value;
  // blocking assignments here would collapse the synchroniser into a single flop.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      row_meta_q <= 4'hF;
      row_sync_q <= 4'hF;
    end else begin
      row_meta_q <= row;
      row_sync_q <= row_meta_q;
    end
  end

  assign slot_last = (slot_q == SLOT_LAST);
  assign frame_end = slot_last && (col_idx_q == 2'd3);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      slot_q    <= '0;
      col_idx_q <= 2'd0;
    end else if (slot_last) begin
      slot_q    <= '0;
      col_idx_q <= col_idx_q + 2'd1;
    end else begin
      slot_q    <= slot_q + SLOT_ONE;
    end
  end

  // Map including the sample taken this cycle, so frame end sees slot 3's rows.
  // NOTE: every always_comb assigns its outputs a default first, so no path can
  // leave a variable unassigned and infer a latch.
  always_comb begin
    sample_map = map_q;
    for (int r = 0; r < 4; r++) begin
      if (!row_sync_q[r]) sample_map[{r[1:0], col_idx_q}] = 1'b1;
    end
  end

  always_comb begin
    map_d = map_q;
    if (frame_end)      map_d = '0;
    else if (slot_last) map_d = sample_map;
  end

  always_comb begin
    frame_kind = FR_NONE;
    frame_key  = 4'h0;
    if (sample_map != '0) begin
      if ((sample_map & (sample_map - 16'd1)) == '0) frame_kind = FR_SINGLE;
      else                                            frame_kind = FR_MULTI;
    end
    for (int i = 15; i >= 0; i--) begin
      if (sample_map[i]) frame_key = 4'(i);
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cand_d      = cand_q;
    key_code_d  = key_code_q;
    key_valid_d = 1'b0;
    key_down_d  = key_down_q;
    accept      = 1'b0;
    drop        = 1'b0;
    if (frame_end) begin
      unique case (state_q)
        ST_IDLE: begin
          if (frame_kind == FR_SINGLE) begin
            cand_d  = frame_key;
            cnt_d   = CNT_ONE;
            state_d = ST_PRESS;
            accept  = (CNT_ONE == CNT_DONE);
          end
        end
        ST_PRESS: begin
          if (frame_kind == FR_SINGLE) begin
            if (frame_key == cand_q) begin
              cnt_d  = cnt_q + CNT_ONE;
              accept = (cnt_d == CNT_DONE);
            end else begin
              cand_d = frame_key;
              cnt_d  = CNT_ONE;
            end
          end else begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end
        end
        ST_HELD: begin
          if (frame_kind == FR_NONE) begin
            cnt_d   = CNT_ONE;
            state_d = ST_RELEASE;
            drop    = (CNT_ONE == CNT_DONE);
          end
        end
        ST_RELEASE: begin
          if (frame_kind == FR_NONE) begin
            cnt_d = cnt_q + CNT_ONE;
            drop  = (cnt_d == CNT_DONE);
          end else begin
            state_d = ST_HELD;
            cnt_d   = '0;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
    if (accept) begin
      key_code_d  = cand_d;
      key_valid_d = 1'b1;
      key_down_d  = 1'b1;
      state_d     = ST_HELD;
      cnt_d       = '0;
    end
    if (drop) begin
      key_down_d = 1'b0;
      state_d    = ST_IDLE;
      cnt_d      = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      map_q       <= '0;
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      cand_q      <= 4'h0;
      key_code_q  <= 4'h0;
      key_valid_q <= 1'b0;
      key_down_q  <= 1'b0;
    end else begin
      map_q       <= map_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cand_q      <= cand_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      key_down_q  <= key_down_d;
    end
  end

  assign col       = ~(4'b0001 << col_idx_q);
  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign key_down  = key_down_q;

endmodule

// File: tb/tb_keypad_scan.sv
// Directed bench for keypad_scan: a passive keypad model answers the column strobes,
// expected key events are queued with their due cycle and matched as pulses appear.
`timescale 1ns/1ps
module tb_keypad_scan;

  localparam int SCAN_DIV = 4;
  localparam int DEBOUNCE = 3;
  localparam int FRAME    = 4 * SCAN_DIV;
  localparam int LAT      = DEBOUNCE * FRAME;

  typedef struct {
    logic [3:0] code;
    int         cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  row, col, key_code;
  logic        key_valid, key_down;
  logic [15:0] keys;

  exp_t sb[$];
  int   total  = 0;
  int   bad    = 0;
  int   tb_cyc = 0;

  always #5 clk = ~clk;

  // Passive switch matrix: a closed key pulls its row low while its column is strobed.
  always_comb begin
    row = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (keys[4*r+c] && !col[c]) row[r] = 1'b0;
      end
    end
  end

  keypad_scan #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE(DEBOUNCE)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .row      (row),
    .col      (col),
    .key_code (key_code),
    .key_valid(key_valid),
    .key_down (key_down)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One cycle forward; any valid pulse is matched against the scoreboard head.
  task automatic step();
    exp_t e;
    @(negedge clk);
    tb_cyc++;
    if (key_valid === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_pulse", {31'd0, key_valid}, 32'd0);
      end else begin
        e = sb.pop_front();
        check("pulse_code", {28'd0, key_code}, {28'd0, e.code});
        check("pulse_cycle", tb_cyc, e.cyc);
        check("pulse_down", {31'd0, key_down}, 32'd1);
      end
    end
  endtask

  task automatic run_to(input int target);
    while (tb_cyc < target) step();
  endtask

  task automatic expect_key(input logic [3:0] code, input int cyc);
    exp_t e;
    e.code = code;
    e.cyc  = cyc;
    sb.push_back(e);
  endtask

  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n  = 1'b1;
    tb_cyc = 0;
    check({tag, "_col"},   {28'd0, col},       32'hE);
    check({tag, "_valid"}, {31'd0, key_valid}, 32'd0);
    check({tag, "_code"},  {28'd0, key_code},  32'd0);
    check({tag, "_down"},  {31'd0, key_down},  32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    keys  = 16'h0000;
    repeat (3) @(negedge clk);
    do_reset("rst0");

    // Column walk: each strobe held for one slot.
    for (int i = 0; i < FRAME; i++) begin
      check($sformatf("scan_col_%0d", i), {28'd0, col}, {28'd0, ~(4'b0001 << (i / SCAN_DIV))});
      step();
    end

    // Single press of row1/col2 (code 6), then release.
    keys = 16'h0040;
    expect_key(4'h6, tb_cyc + LAT);
    run_to(63);
    check("press6_down_before", {31'd0, key_down}, 32'd0);
    run_to(176);
    check("press6_down_held", {31'd0, key_down}, 32'd1);
    check("press6_code_held", {28'd0, key_code}, 32'h6);
    keys = 16'h0000;
    run_to(223);
    check("rel6_down_before", {31'd0, key_down}, 32'd1);
    step();
    check("rel6_down_after", {31'd0, key_down}, 32'd0);
    check("rel6_code_kept", {28'd0, key_code}, 32'h6);
    check("press6_sb_empty", sb.size(), 32'd0);

    // Bounce on key 0: pressed and released on alternate frames.
    for (int f = 0; f < 12; f++) begin
      keys = (f % 2 == 0) ? 16'h0001 : 16'h0000;
      run_to(tb_cyc + FRAME);
      check($sformatf("bounce_down_%0d", f), {31'd0, key_down}, 32'd0);
    end
    keys = 16'h0000;
    check("bounce_sb_empty", sb.size(), 32'd0);

    // Keys 1 and A together, then only key 1.
    keys = 16'h0402;
    run_to(tb_cyc + 8 * FRAME);
    check("multi_down", {31'd0, key_down}, 32'd0);
    check("multi_code_kept", {28'd0, key_code}, 32'h6);
    keys = 16'h0002;
    expect_key(4'h1, tb_cyc + LAT);
    run_to(tb_cyc + LAT + FRAME);
    check("multi_then1_down", {31'd0, key_down}, 32'd1);
    check("multi_then1_code", {28'd0, key_code}, 32'h1);
    keys = 16'h0000;
    run_to(tb_cyc + LAT + FRAME);
    check("multi_rel_down", {31'd0, key_down}, 32'd0);
    check("multi_sb_empty", sb.size(), 32'd0);

    // Reset during PRESS after two good frames of key 5; key stays held.
    keys = 16'h0020;
    run_to(tb_cyc + 2 * FRAME);
    do_reset("rst_press");
    expect_key(4'h5, LAT);
    run_to(60);
    check("rst_press_down", {31'd0, key_down}, 32'd1);
    do_reset("rst_held");
    expect_key(4'h5, LAT);
    run_to(LAT - 1);
    check("rst_held_down_before", {31'd0, key_down}, 32'd0);
    run_to(64);
    check("rst_held_down_after", {31'd0, key_down}, 32'd1);
    keys = 16'h0000;
    run_to(111);
    check("rst_rel_down_before", {31'd0, key_down}, 32'd1);
    step();
    check("rst_rel_down_after", {31'd0, key_down}, 32'd0);
    check("rst_sb_empty", sb.size(), 32'd0);

    // Back-to-back: F, release, then 3.
    keys = 16'h8000;
    expect_key(4'hF, tb_cyc + LAT);
    run_to(176);
    keys = 16'h0000;
    run_to(223);
    check("b2b_f_down_before", {31'd0, key_down}, 32'd1);
    step();
    check("b2b_f_down_after", {31'd0, key_down}, 32'd0);
    keys = 16'h0008;
    expect_key(4'h3, tb_cyc + LAT);
    run_to(271);
    check("b2b_gap_down", {31'd0, key_down}, 32'd0);
    check("b2b_gap_code", {28'd0, key_code}, 32'hF);
    run_to(288);
    check("b2b_3_down", {31'd0, key_down}, 32'd1);
    check("b2b_3_code", {28'd0, key_code}, 32'h3);
    check("b2b_sb_empty", sb.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
